// File: rtl/risc_sequencer_if.sv
// Datapath-facing bundle for risc_sequencer: IR/flag/memory inputs, phase, strobes and status.
// master is the sequencer side and slave is the datapath side.
interface risc_sequencer_if #(
  parameter int unsigned OPCODE_W = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_rdy;
  logic                go;
  logic [2:0]          phase;
  logic                sel;
  logic                rd;
  logic                ld_ir;
  logic                inc_pc;
  logic                halt;
  logic                ld_pc;
  logic                data_e;
  logic                ld_ac;
  logic                wr;
  logic                halted;
  logic                timeout_err;
  logic                illegal;

  modport master (
    input  opcode, zero, mem_rdy, go,
    output phase, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr,
    output halted, timeout_err, illegal
  );

  modport slave (
    output opcode, zero, mem_rdy, go,
    input  phase, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr,
    input  halted, timeout_err, illegal
  );
endinterface

// File: rtl/risc_sequencer.sv
// Self-sequencing VeriRISC controller: 8-phase cycle counter with decoded datapath strobes.
// Define RISC_SEQ_WAIT_EN to honour mem_rdy wait states and the stall timeout.
module risc_sequencer #(
  parameter int unsigned OPCODE_W = 3,
  parameter int unsigned TIMEOUT  = 15
) (
  input logic              clk,
  input logic              rst_,
  risc_sequencer_if.master bus
);
  localparam logic [2:0] OpHlt = 3'd0;
  localparam logic [2:0] OpSkz = 3'd1;
  localparam logic [2:0] OpAdd = 3'd2;
  localparam logic [2:0] OpAnd = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpLda = 3'd5;
  localparam logic [2:0] OpSto = 3'd6;
  localparam logic [2:0] OpJmp = 3'd7;

  logic [2:0] phase_q, phase_d;
  logic       halted_q, halted_d;
  logic       hlt_q, hlt_d;
  logic       stall, timeout_hit;
  logic [2:0] op;
  logic       legal;
  logic       is_hlt, is_skz, is_alu, is_sto, is_jmp;
  logic       sel_r, rd_r, ld_ir_r, inc_pc_r, halt_r, ld_pc_r, data_e_r, ld_ac_r, wr_r;
  logic       mem_phase;

  assign op = bus.opcode[2:0];

  generate
    if (OPCODE_W > 3) begin : g_wide
      assign legal = ~|bus.opcode[OPCODE_W-1:3];
    end else begin : g_narrow
      assign legal = 1'b1;
    end
  endgenerate

  assign is_hlt = legal && (op == OpHlt);
  assign is_skz = legal && (op == OpSkz);
  assign is_alu = legal && ((op == OpAdd) || (op == OpAnd) || (op == OpXor) || (op == OpLda));
  assign is_sto = legal && (op == OpSto);
  assign is_jmp = legal && (op == OpJmp);

  // Raw decode ignores halted so the memory-phase test stays valid while frozen.
  always_comb begin
    sel_r    = (phase_q <= 3'd3);
    rd_r     = ((phase_q >= 3'd1) && (phase_q <= 3'd3)) || ((phase_q >= 3'd5) && is_alu);
    ld_ir_r  = (phase_q == 3'd2) || (phase_q == 3'd3);
    inc_pc_r = (phase_q == 3'd4) || ((phase_q == 3'd6) && is_skz && bus.zero);
    halt_r   = (phase_q == 3'd4) && is_hlt;
    ld_pc_r  = (phase_q >= 3'd6) && is_jmp;
    data_e_r = (phase_q >= 3'd6) && is_sto;
    ld_ac_r  = (phase_q == 3'd7) && is_alu;
    wr_r     = (phase_q == 3'd7) && is_sto;
  end

  assign mem_phase = rd_r | wr_r;

  assign bus.phase   = phase_q;
  assign bus.sel     = sel_r & ~halted_q;
  assign bus.rd      = rd_r & ~halted_q;
  assign bus.ld_ir   = ld_ir_r & ~halted_q;
  assign bus.inc_pc  = inc_pc_r & ~halted_q;
  assign bus.halt    = halted_q ? hlt_q : halt_r;
  assign bus.ld_pc   = ld_pc_r & ~halted_q;
  assign bus.data_e  = data_e_r & ~halted_q;
  assign bus.ld_ac   = ld_ac_r & ~halted_q;
  assign bus.wr      = wr_r & ~halted_q;
  assign bus.halted  = halted_q;
  assign bus.illegal = ~halted_q & ~legal & (phase_q == 3'd4);

`ifdef RISC_SEQ_WAIT_EN
  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  logic [7:0] cnt_q, cnt_d;
  logic       terr_q, terr_d;

  assign stall       = mem_phase & ~bus.mem_rdy;
  assign timeout_hit = stall & (cnt_q == TimeoutCnt);

  always_comb begin
    cnt_d  = cnt_q;
    terr_d = terr_q;
    if (halted_q) begin
      if (bus.go) begin
        cnt_d  = '0;
        terr_d = 1'b0;
      end
    end else if (timeout_hit) begin
      terr_d = 1'b1;
    end else if (stall) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end

  assign bus.timeout_err = terr_q;
`else
  logic unused_mem_rdy;

  assign unused_mem_rdy  = bus.mem_rdy;
  assign stall           = 1'b0;
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    hlt_d    = hlt_q;
    if (halted_q) begin
      if (bus.go) begin
        halted_d = 1'b0;
        hlt_d    = 1'b0;
        if (!stall) phase_d = phase_q + 3'd1;
      end
    end else if (timeout_hit) begin
      halted_d = 1'b1;
    end else if (!stall) begin
      phase_d = phase_q + 3'd1;
      if (halt_r) begin
        halted_d = 1'b1;
        hlt_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      phase_q  <= '0;
      halted_q <= 1'b0;
      hlt_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
      hlt_q    <= hlt_d;
    end
  end
endmodule

// File: tb/tb_risc_sequencer.sv
// Self-checking bench for risc_sequencer (OPCODE_W=4, TIMEOUT=4): vector table plus
// hand-written halt, stall, illegal and reset sequences, all checked through a scoreboard.
module tb_risc_sequencer;
  localparam int unsigned OpW = 4;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  risc_sequencer_if #(.OPCODE_W(OpW)) bus ();

  risc_sequencer #(
    .OPCODE_W(OpW),
    .TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus)
  );

  // Strobe order: {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr}
  // Flag order:   {halted, timeout_err, illegal}
  typedef struct {
    logic [3:0] op;
    logic       zero;
    logic       rdy;
    logic       go;
    logic       rst;
    logic [2:0] ph;
    logic [8:0] str;
    logic [2:0] flg;
  } vec_t;

  typedef struct {
    string      tag;
    logic [2:0] ph;
    logic [8:0] str;
    logic [2:0] flg;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic [3:0] op, input logic zero, input logic rdy,
                              input logic [2:0] ph, input logic [8:0] str);
    vec_t v;
    v.op = op; v.zero = zero; v.rdy = rdy; v.go = 1'b0; v.rst = 1'b1;
    v.ph = ph; v.str = str; v.flg = 3'b000;
    return v;
  endfunction

  // Fetch phases 0-4 for a legal opcode; mem_rdy low in the non-memory phases 0 and 4.
  task automatic add_fetch(input logic [3:0] op, input logic zero);
    tbl.push_back(mk(op, zero, 1'b0, 3'd0, 9'b100000000));
    tbl.push_back(mk(op, zero, 1'b1, 3'd1, 9'b110000000));
    tbl.push_back(mk(op, zero, 1'b1, 3'd2, 9'b111000000));
    tbl.push_back(mk(op, zero, 1'b1, 3'd3, 9'b111000000));
    tbl.push_back(mk(op, zero, 1'b0, 3'd4, 9'b000100000));
  endtask

  task automatic compare();
    exp_t       e;
    logic [8:0] s;
    logic [2:0] f;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: no expectation queued");
      return;
    end
    e = sb.pop_front();
    s = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.halt, bus.ld_pc, bus.data_e, bus.ld_ac,
         bus.wr};
    f = {bus.halted, bus.timeout_err, bus.illegal};
    checks++;
    if (bus.phase !== e.ph) begin
      errors++;
      $display("FAIL %s phase: got %0d want %0d", e.tag, bus.phase, e.ph);
    end
    checks++;
    if (s !== e.str) begin
      errors++;
      $display("FAIL %s strobes: got %b want %b", e.tag, s, e.str);
    end
    checks++;
    if (f !== e.flg) begin
      errors++;
      $display("FAIL %s flags(halted,terr,illegal): got %b want %b", e.tag, f, e.flg);
    end
  endtask

  // One clock: drive inputs, queue the expectation, sample at the falling edge.
  task automatic cyc(input string tag, input logic [3:0] op, input logic zero, input logic rdy,
                     input logic go, input logic rst, input logic [2:0] ph,
                     input logic [8:0] str, input logic [2:0] flg);
    exp_t e;
    bus.opcode  = op;
    bus.zero    = zero;
    bus.mem_rdy = rdy;
    bus.go      = go;
    rst_        = rst;
    e.tag = tag; e.ph = ph; e.str = str; e.flg = flg;
    sb.push_back(e);
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic run_fetch(input string tag, input logic [3:0] op, input logic [8:0] str4,
                           input logic [2:0] flg4);
    cyc(tag, op, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 9'b100000000, 3'b000);
    cyc(tag, op, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 9'b110000000, 3'b000);
    cyc(tag, op, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 9'b111000000, 3'b000);
    cyc(tag, op, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 9'b111000000, 3'b000);
    cyc(tag, op, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, str4, flg4);
  endtask

  initial begin
    vec_t v;
    bus.opcode  = 4'd2;
    bus.zero    = 1'b0;
    bus.mem_rdy = 1'b1;
    bus.go      = 1'b0;
    rst_        = 1'b0;
    @(posedge clk);
    #1;

    // Reset state, then ADD, STO, JMP, SKZ(zero=1), SKZ(zero=0) back to back.
    v = mk(4'd2, 1'b0, 1'b1, 3'd0, 9'b100000000);
    v.rst = 1'b0;
    tbl.push_back(v);
    add_fetch(4'd2, 1'b0);
    tbl.push_back(mk(4'd2, 1'b0, 1'b1, 3'd5, 9'b010000000));
    tbl.push_back(mk(4'd2, 1'b0, 1'b1, 3'd6, 9'b010000000));
    tbl.push_back(mk(4'd2, 1'b0, 1'b1, 3'd7, 9'b010000010));
    add_fetch(4'd6, 1'b0);
    tbl.push_back(mk(4'd6, 1'b0, 1'b0, 3'd5, 9'b000000000));
    tbl.push_back(mk(4'd6, 1'b0, 1'b0, 3'd6, 9'b000000100));
    tbl.push_back(mk(4'd6, 1'b0, 1'b1, 3'd7, 9'b000000101));
    add_fetch(4'd7, 1'b0);
    tbl.push_back(mk(4'd7, 1'b0, 1'b0, 3'd5, 9'b000000000));
    tbl.push_back(mk(4'd7, 1'b0, 1'b0, 3'd6, 9'b000001000));
    tbl.push_back(mk(4'd7, 1'b0, 1'b0, 3'd7, 9'b000001000));
    add_fetch(4'd1, 1'b1);
    tbl.push_back(mk(4'd1, 1'b1, 1'b1, 3'd5, 9'b000000000));
    tbl.push_back(mk(4'd1, 1'b1, 1'b1, 3'd6, 9'b000100000));
    tbl.push_back(mk(4'd1, 1'b1, 1'b1, 3'd7, 9'b000000000));
    add_fetch(4'd1, 1'b0);
    tbl.push_back(mk(4'd1, 1'b0, 1'b1, 3'd5, 9'b000000000));
    tbl.push_back(mk(4'd1, 1'b0, 1'b1, 3'd6, 9'b000000000));
    tbl.push_back(mk(4'd1, 1'b0, 1'b1, 3'd7, 9'b000000000));

    foreach (tbl[i]) begin
      cyc($sformatf("vec%0d", i), tbl[i].op, tbl[i].zero, tbl[i].rdy, tbl[i].go, tbl[i].rst,
          tbl[i].ph, tbl[i].str, tbl[i].flg);
    end

    // HLT freezes at phase 5 for 10 cycles; go resumes at 6, 7, 0.
    run_fetch("hlt", 4'd0, 9'b000110000, 3'b000);
    for (int i = 0; i < 10; i++) begin
      cyc("hlt_hold", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 9'b000010000, 3'b100);
    end
    cyc("hlt_go", 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 9'b000010000, 3'b100);
    cyc("hlt_res6", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 9'b000000000, 3'b000);
    cyc("hlt_res7", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 9'b000000000, 3'b000);

`ifdef RISC_SEQ_WAIT_EN
    // Three wait states at phase 1, then timeout at phase 2, then the TIMEOUT boundary at 3.
    cyc("stall_p0", 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 9'b100000000, 3'b000);
    for (int i = 0; i < 3; i++) begin
      cyc("stall_p1", 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 9'b110000000, 3'b000);
    end
    cyc("stall_p1_rdy", 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 9'b110000000, 3'b000);
    for (int i = 0; i < 5; i++) begin
      cyc("tmo_count", 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 9'b111000000, 3'b000);
    end
    cyc("tmo_set", 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 9'b000000000, 3'b110);
    cyc("tmo_go", 4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 9'b000000000, 3'b110);
    for (int i = 0; i < 4; i++) begin
      cyc("tmo_edge", 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 9'b111000000, 3'b000);
    end
    cyc("tmo_edge_rdy", 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 9'b111000000, 3'b000);
`else
    // mem_rdy is ignored: memory phases advance every cycle.
    cyc("nowait_p0", 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 9'b100000000, 3'b000);
    cyc("nowait_p1", 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 9'b110000000, 3'b000);
    cyc("nowait_p2", 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 9'b111000000, 3'b000);
    cyc("nowait_p3", 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 9'b111000000, 3'b000);
`endif
    cyc("after_p4", 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 9'b000100000, 3'b000);
    cyc("after_p5", 4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 9'b010000000, 3'b000);
    cyc("after_p6", 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 9'b010000000, 3'b000);
    cyc("after_p7", 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 9'b010000010, 3'b000);

    // Opcode 9 is illegal: pulse at phase 4, silent phases 5-7, stray go ignored.
    run_fetch("ill", 4'd9, 9'b000100000, 3'b001);
    cyc("ill_p5", 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 9'b000000000, 3'b000);
    cyc("ill_p6", 4'd9, 1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 9'b000000000, 3'b000);
    cyc("ill_p7", 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 9'b000000000, 3'b000);

`ifdef RISC_SEQ_WAIT_EN
    // LDA times out at phase 5; reset overrides the frozen state.
    run_fetch("rst_lda", 4'd5, 9'b000100000, 3'b000);
    for (int i = 0; i < 5; i++) begin
      cyc("rst_stall", 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 9'b010000000, 3'b000);
    end
    cyc("rst_frozen", 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 9'b000000000, 3'b110);
    cyc("rst_assert", 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 9'b000000000, 3'b110);
`else
    run_fetch("rst_hlt", 4'd0, 9'b000110000, 3'b000);
    cyc("rst_frozen", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 9'b000010000, 3'b100);
    cyc("rst_assert", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 9'b000010000, 3'b100);
`endif
    cyc("rst_done", 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 9'b100000000, 3'b000);
    cyc("rst_run", 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 9'b110000000, 3'b000);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d left want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/risc_sequencer.md
# risc_sequencer

Self-sequencing instruction controller for the VeriRISC CPU: it owns the 8-phase instruction cycle counter and drives the same datapath strobes as the combinational controller, decoded from the current phase. It adds memory wait-state handling with a stall timeout, halt/resume control, and illegal-opcode detection for wider opcodes. It sits between the instruction register/accumulator zero flag and the memory, program counter, accumulator and IR load enables.

## Interface
- `OPCODE_W`, default 3: opcode width, ≥3. Only the values 0–7 are legal.
- `TIMEOUT`, default 15: consecutive stall cycles allowed before a timeout error, range 1–255.
- `clk`, input, 1: rising-edge clock. The block has one clock.
- `rst_`, input, 1: reset. Synchronous and active-low.
- `opcode`, input, OPCODE_W: the IR opcode. HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- `zero`, input, 1: the accumulator is zero.
- `mem_rdy`, input, 1: memory has completed the current access.
- `go`, input, 1: single-cycle resume request.
- `phase`, output, 3: current phase register.
- `sel`, `rd`, `ld_ir`, `inc_pc`, `halt`, `ld_pc`, `data_e`, `ld_ac`, `wr`: outputs, 1 bit each. These are the datapath strobes.
- `halted`, output, 1: the sequencer is frozen.
- `timeout_err`, output, 1: sticky memory-stall timeout flag.
- `illegal`, output, 1: pulse at phase 4 for an opcode above 7.

## Operation
- **Strobe decode.** Strobes are combinational from `phase`, `opcode` and `zero`. All strobes are 0 while `halted`=1, except `halt`.
  - `sel`: phases 0–3.
  - `rd`: phases 1–3, and phases 5–7 for ALUOP (ADD, AND, XOR, LDA).
  - `ld_ir`: phases 2–3.
  - `inc_pc`: phase 4 for any opcode, and phase 6 when SKZ with `zero`=1.
  - `halt`: phase 4 for HLT, and held high while halted by HLT.
  - `ld_pc`: phases 6–7 for JMP.
  - `data_e`: phases 6–7 for STO.
  - `ld_ac`: phase 7 for ALUOP.
  - `wr`: phase 7 for STO.
- **Illegal opcodes.** When `opcode` is above 7, the fetch and phase 4 run normally, no phase 5–7 strobes are driven, and `illegal`=1 at phase 4.
- **Memory phases.** A memory phase is any phase in which `rd` or `wr` is asserted.
- **Phase advance.** `phase` advances by 1 (modulo 8, 7→0 wraps) each clock when `halted`=0 and either the phase is not a memory phase or `mem_rdy`=1. Otherwise the phase holds (stall).
- **Stall counter.** It increments on each stall cycle and clears on every advance.
  - When the counter equals TIMEOUT and `mem_rdy` is still 0, the next edge sets `timeout_err` and `halted`. `phase` holds.
- **HLT.** On the edge leaving phase 4 with HLT, `phase` becomes 5 and `halted` is set.
- **Resume.** `go`=1 while halted clears `halted`, `timeout_err` and the stall counter at the next edge. The phase then continues from its held value.
- **Ignored inputs.** `go` while not halted is ignored. `mem_rdy` in a non-memory phase is ignored.
- **Reset.** `rst_` low at an edge sets `phase`=0 and clears `halted`, `timeout_err` and the stall counter, overriding everything else including mid-stall and mid-halt.

## Timing
- Reset values: `phase`=0, `halted`=0, `timeout_err`=0. After reset only `sel`=1; every other strobe and `illegal` are 0.
- Strobes are valid in the same cycle as `phase`, with zero latency from the `opcode`/`zero` inputs.
- With no waits, one instruction takes exactly 8 cycles.
- Each cycle `mem_rdy` stays low in a memory phase adds 1 cycle.
- A timeout is declared on the (TIMEOUT+1)th consecutive low-`mem_rdy` cycle.
- `go` to the first advanced phase takes 1 cycle.
- If `mem_rdy` rises on the same cycle the counter reaches TIMEOUT, the block advances and no error is raised.

## Configuration
- Macro `RISC_SEQ_WAIT_EN`.
  - Defined: `mem_rdy` stalls are honoured and the timeout is active.
  - Undefined: `mem_rdy` is ignored, the phase advances every non-halted cycle, `timeout_err` is constant 0, and the stall counter is not built.
  - HLT/`go` behaviour is identical in both builds.

## Test plan
- Reset, then `mem_rdy`=1 and `opcode`=ADD: the strobe vector {`sel`,`rd`,`ld_ir`,`inc_pc`,`halt`,`ld_pc`,`data_e`,`ld_ac`,`wr`} follows 100000000, 110000000, 111000000, 111000000, 000100000, 010000000, 010000000, 010000010, and `phase` wraps to 0.
- STO, then JMP, then SKZ with `zero`=1: phase 7 gives 000000101 for STO, phase 6 gives 000001000 for JMP, and phase 6 gives `inc_pc`=1 only for SKZ.
- HLT: after phase 4, `phase`=5, `halted`=1 and `halt`=1 are held for 10 cycles. `go` then gives phases 6, 7, 0 on the following edges.
- `mem_rdy`=0 for 3 cycles at phase 1: `phase` holds for 3 cycles and reaches 2 on the cycle after `mem_rdy` rises. With `TIMEOUT`=4 and `mem_rdy` held low, `timeout_err`=`halted`=1 after 5 stall cycles, and `go` with `mem_rdy`=1 clears both.
- `OPCODE_W`=4, `opcode`=9: `illegal`=1 at phase 4 only, and phases 5–7 show all strobes 0.
- Assert `rst_`=0 while halted at phase 5 with `timeout_err`=1: the next edge gives `phase`=0 with all flags 0.
